sensor_frame_receiver: RTL and testbench

- FPGA-side receiver for the 12-bit parallel sensor interface: D[11:0], HACT, VACT and BPF, plus the active-low ARO trigger.
- Requests a frame by pulsing ARO low, then waits for the VACT rising edge.
- Captures the frame and outputs a pixel stream with sof/eol/eof markers, measured width/height, and geometry and timeout error pulses.
- Sits between the sensor pins and the downstream frame-buffer writer.

---
 rtl/sensor_frame_receiver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sensor_frame_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_receiver.sv
// sensor_frame_receiver: receiver for the 12-bit parallel sensor port.
// Requests a frame with an active-low ARO pulse, waits for VACT to rise,
// then re-emits the frame as a pixel stream with sof/eol/eof markers,
// measured geometry and error pulses.
// Optional build macro: SENSOR_RX_BPF_CAPTURE_EN (adds the bpfv output and
// forwards black-pixel-flag cycles instead of dropping them).
module sensor_frame_receiver #(
    parameter int NCOLS   = 66,
    parameter int NROWS   = 18,
    parameter int ARO_LEN = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        trig,
    input  logic        cont,
    input  logic [11:0] sens_d,
    input  logic        sens_hact,
    input  logic        sens_vact,
    input  logic        sens_bpf,
    output logic        aro,
    output logic [11:0] pxd,
    output logic        pxv,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic [11:0] width,
    output logic [11:0] height,
    output logic        err_geom,
    output logic        err_timeout,
    output logic        busy
`ifdef SENSOR_RX_BPF_CAPTURE_EN
    ,
    output logic        bpfv
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FRAME = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // TRIG exits on its last ARO cycle; WAIT gives up one cycle early so the
    // error lands ARO_LEN + TIMEOUT cycles after the cycle trig was high.
    localparam logic [15:0] ARO_LAST = 16'(ARO_LEN - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 2);
    localparam logic [11:0] NCOLS_W  = 12'(NCOLS);
    localparam logic [11:0] NROWS_W  = 12'(NROWS);

    state_t      state_r, state_next_s;
    logic [15:0] cnt_r, cnt_next_s;
    logic        timeout_s;

    logic [11:0] s1_d_r, s2_d_r;
    logic        s1_hact_r, s2_hact_r, s1_vact_r, s2_vact_r, s1_bpf_r, s2_bpf_r;

    logic [11:0] col_r, rows_r;
    logic        sof_pend_r;

    logic        in_frame_s, act_pix_s, emit_s, vact_rise_s, vact_fall_s;
    logic        line_end_s, frame_start_s;
    logic [11:0] col_inc_s, width_new_s, rows_inc_s, rows_new_s;

    // Edge detection and per-pixel qualifiers derived from the two input stages.
    always_comb begin
        in_frame_s    = (state_r == ST_FRAME);
        vact_rise_s   = s1_vact_r & ~s2_vact_r;
        vact_fall_s   = s2_vact_r & ~s1_vact_r;
        frame_start_s = (state_r == ST_WAIT) & vact_rise_s;
        act_pix_s     = in_frame_s & s2_hact_r & ~s2_bpf_r;
`ifdef SENSOR_RX_BPF_CAPTURE_EN
        emit_s        = in_frame_s & s2_hact_r;
`else
        emit_s        = act_pix_s;
`endif
        // A line also closes when VACT drops under a still-high HACT.
        line_end_s    = in_frame_s & s2_hact_r & (~s1_hact_r | vact_fall_s);
        if (col_r == 12'hFFF) begin
            col_inc_s = col_r;
        end else begin
            col_inc_s = col_r + 12'd1;
        end
        if (act_pix_s) begin
            width_new_s = col_inc_s;
        end else begin
            width_new_s = col_r;
        end
        if (rows_r == 12'hFFF) begin
            rows_inc_s = rows_r;
        end else begin
            rows_inc_s = rows_r + 12'd1;
        end
        if (line_end_s) begin
            rows_new_s = rows_inc_s;
        end else begin
            rows_new_s = rows_r;
        end
    end

    // Next-state and cycle counter for the request / wait / capture sequence.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = 16'd0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig || cont) begin
                    state_next_s = ST_TRIG;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TRIG: begin
                if (cnt_r == ARO_LAST) begin
                    state_next_s = ST_WAIT;
                end else begin
                    cnt_next_s = cnt_r + 16'd1;
                end
            end
            ST_WAIT: begin
                if (vact_rise_s) begin
                    state_next_s = ST_FRAME;
                end else if (cnt_r == TO_LAST) begin
                    state_next_s = ST_IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + 16'd1;
                end
            end
            ST_FRAME: begin
                if (vact_fall_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FRAME;
                end
            end
            ST_DONE: begin
                if (cont) begin
                    state_next_s = ST_TRIG;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and shared TRIG/WAIT cycle counter.
    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Two-stage capture of the sensor pins.
    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            s1_d_r    <= 12'd0;
            s2_d_r    <= 12'd0;
            s1_hact_r <= 1'b0;
            s2_hact_r <= 1'b0;
            s1_vact_r <= 1'b0;
            s2_vact_r <= 1'b0;
            s1_bpf_r  <= 1'b0;
            s2_bpf_r  <= 1'b0;
        end else begin
            s1_d_r    <= sens_d;
            s2_d_r    <= s1_d_r;
            s1_hact_r <= sens_hact;
            s2_hact_r <= s1_hact_r;
            s1_vact_r <= sens_vact;
            s2_vact_r <= s1_vact_r;
            s1_bpf_r  <= sens_bpf;
            s2_bpf_r  <= s1_bpf_r;
        end
    end

    // Column/row counters and the pending-sof flag for the frame in progress.
    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            col_r      <= 12'd0;
            rows_r     <= 12'd0;
            sof_pend_r <= 1'b0;
        end else begin
            if (s1_hact_r && !s2_hact_r) begin
                col_r <= 12'd0;
            end else if (act_pix_s) begin
                col_r <= col_inc_s;
            end else begin
                col_r <= col_r;
            end
            if (frame_start_s) begin
                rows_r     <= 12'd0;
                sof_pend_r <= 1'b1;
            end else begin
                rows_r     <= rows_new_s;
                sof_pend_r <= sof_pend_r & ~act_pix_s;
            end
        end
    end

    // Registered pixel stream, markers, geometry and status outputs.
    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            aro         <= 1'b1;
            pxd         <= 12'd0;
            pxv         <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            width       <= 12'd0;
            height      <= 12'd0;
            err_geom    <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            aro         <= (state_r != ST_TRIG);
            pxd         <= s2_d_r;
            pxv         <= emit_s;
            sof         <= act_pix_s & sof_pend_r;
            eol         <= act_pix_s & line_end_s;
            eof         <= (state_r == ST_DONE);
            if (line_end_s) begin
                width <= width_new_s;
            end else begin
                width <= width;
            end
            if (in_frame_s && vact_fall_s) begin
                height <= rows_new_s;
            end else begin
                height <= height;
            end
            err_geom    <= (line_end_s & (width_new_s != NCOLS_W)) |
                           ((state_r == ST_DONE) & (height != NROWS_W));
            err_timeout <= timeout_s;
            busy        <= (state_next_s != ST_IDLE);
        end
    end

`ifdef SENSOR_RX_BPF_CAPTURE_EN
    // Marks forwarded black-pixel-flag cycles.
    always_ff @(posedge MCLK) begin
        if (!MRST) begin
            bpfv <= 1'b0;
        end else begin
            bpfv <= in_frame_s & s2_hact_r & s2_bpf_r;
        end
    end
`endif

endmodule

// File: tb/tb_sensor_frame_receiver.sv
// Directed bench for sensor_frame_receiver (default build, BPF dropped).
// A behavioural sensor drives ramp frames; a per-cycle monitor checks the
// pixel stream and tallies markers; the main sequence checks the tallies.
module tb_sensor_frame_receiver;

    logic        MCLK = 1'b0;
    logic        MRST, trig, cont, sens_hact, sens_vact, sens_bpf;
    logic [11:0] sens_d;
    logic        aro, pxv, sof, eol, eof, err_geom, err_timeout, busy;
    logic [11:0] pxd, width, height;

    always #5 MCLK = ~MCLK;

    sensor_frame_receiver #(.NCOLS(66), .NROWS(18), .ARO_LEN(4), .TIMEOUT(4096)) dut (
        .MCLK(MCLK), .MRST(MRST), .trig(trig), .cont(cont),
        .sens_d(sens_d), .sens_hact(sens_hact), .sens_vact(sens_vact), .sens_bpf(sens_bpf),
        .aro(aro), .pxd(pxd), .pxv(pxv), .sof(sof), .eol(eol), .eof(eof),
        .width(width), .height(height), .err_geom(err_geom),
        .err_timeout(err_timeout), .busy(busy)
    );

    int vecs = 0;
    int fails = 0;
    int cyc = 0;
    int pxv_cnt, sof_cnt, eol_cnt, eof_cnt, geom_cnt, geom_eol_cnt, geom_eof_cnt, to_cnt;
    int aro_falls, aro_run, aro_len, eof_cyc, eol_cyc, to_cyc, mrow, mcol, tc, n;
    logic [11:0] geom_w, geom_h;
    logic aro_q = 1'b1;
    bit   chk_gap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        pxv_cnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0; geom_cnt = 0;
        geom_eol_cnt = 0; geom_eof_cnt = 0; to_cnt = 0; aro_falls = 0;
        aro_run = 0; aro_len = 0; eof_cyc = 0; eol_cyc = 0; to_cyc = 0;
        geom_w = 12'd0; geom_h = 12'd0;
    endtask

    task automatic monitor();
        logic [11:0] e;
        cyc++;
        if (MRST !== 1'b1) begin
            mrow = 0; mcol = 0; aro_q = 1'b1;
        end else begin
            if (pxv === 1'b1) begin
                pxv_cnt++;
                e = 12'((mrow % 16) * 256 + mcol);
                chk("pxd", pxd, e);
                chk("sof_pos", sof, (mrow == 0 && mcol == 0));
                if (sof === 1'b1) sof_cnt++;
                mcol++;
                if (eol === 1'b1) begin
                    eol_cnt++; eol_cyc = cyc; mrow++; mcol = 0;
                    if (err_geom === 1'b1) begin geom_eol_cnt++; geom_w = width; end
                end
            end
            if (eof === 1'b1) begin
                eof_cnt++; eof_cyc = cyc; mrow = 0; mcol = 0;
                chk("eof_no_pxv", pxv, 0);
                if (err_geom === 1'b1) begin geom_eof_cnt++; geom_h = height; end
            end
            if (err_geom === 1'b1) geom_cnt++;
            if (err_timeout === 1'b1) begin to_cnt++; to_cyc = cyc; end
            if (aro_q === 1'b1 && aro === 1'b0) begin
                aro_falls++; aro_run = 0;
                if (chk_gap) chk("eof_to_aro", cyc - eof_cyc, 1);
            end
            if (aro === 1'b0) aro_run++;
            else if (aro_q === 1'b0) aro_len = aro_run;
            aro_q = aro;
        end
    endtask

    task automatic tick();
        @(negedge MCLK);
        monitor();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wait_aro(input logic lvl, input int lim);
        int k;
        k = 0;
        while (aro_q !== lvl && k < lim) begin tick(); k++; end
        chk("wait_aro", aro_q, lvl);
    endtask

    task automatic start_frame();
        trig = 1'b1; tick(); trig = 1'b0;
        wait_aro(1'b0, 10); wait_aro(1'b1, 10);
        repeat (2) tick();
    endtask

    // Sensor model: ramp frame, optional short row, truncated last row,
    // leading BPF pixels per line, or an in-line reset abort.
    task automatic drive_frame(input int nrows, input int ncols, input int short_row,
                               input int trunc, input int nbpf, input int ab_row, input int ab_col);
        int w;
        sens_vact = 1'b1; repeat (3) tick();
        for (int r = 0; r < nrows; r++) begin
            w = (r == short_row) ? ncols - 1 : ncols;
            if (trunc > 0 && r == nrows - 1) w = trunc;
            for (int b = 0; b < nbpf; b++) begin
                sens_hact = 1'b1; sens_bpf = 1'b1; sens_d = 12'hFFF; tick();
            end
            sens_bpf = 1'b0;
            for (int c = 0; c < w; c++) begin
                sens_hact = 1'b1; sens_d = 12'((r % 16) * 256 + c);
                if (r == ab_row && c == ab_col) begin
                    MRST = 1'b0; tick(); MRST = 1'b1;
                    sens_hact = 1'b0; sens_vact = 1'b0;
                    return;
                end
                tick();
            end
            if (trunc > 0 && r == nrows - 1) begin
                sens_vact = 1'b0; repeat (2) tick();
                sens_hact = 1'b0; tick();
                return;
            end
            sens_hact = 1'b0; repeat (4) tick();
        end
        sens_vact = 1'b0; tick();
    endtask

    initial begin
        MRST = 1'b0; trig = 1'b0; cont = 1'b0;
        sens_hact = 1'b0; sens_vact = 1'b0; sens_bpf = 1'b0; sens_d = 12'd0;
        clr();
        repeat (3) tick();
        chk("rst_aro", aro, 1); chk("rst_pxd", pxd, 0); chk("rst_pxv", pxv, 0);
        chk("rst_eof", eof, 0); chk("rst_width", width, 0); chk("rst_height", height, 0);
        chk("rst_busy", busy, 0); chk("rst_errs", {err_geom, err_timeout, sof, eol}, 0);
        MRST = 1'b1; repeat (2) tick();

        // Nominal frame, with a stray trig during WAIT that must be ignored
        clr();
        trig = 1'b1; tick(); trig = 1'b0;
        chk("busy_trig", busy, 1);
        wait_aro(1'b0, 10); wait_aro(1'b1, 10);
        trig = 1'b1; tick(); trig = 1'b0; tick();
        drive_frame(18, 66, -1, 0, 0, -1, -1);
        repeat (8) tick();
        chk("nom_aro_len", aro_len, 4); chk("nom_aro_falls", aro_falls, 1);
        chk("nom_pxv", pxv_cnt, 1188); chk("nom_sof", sof_cnt, 1); chk("nom_eol", eol_cnt, 18);
        chk("nom_eof", eof_cnt, 1); chk("nom_width", width, 66); chk("nom_height", height, 18);
        chk("nom_geom", geom_cnt, 0); chk("nom_to", to_cnt, 0); chk("nom_busy", busy, 0);

        // Continuous mode, three frames with two BPF pixels per line
        clr(); cont = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_aro(1'b0, 20); wait_aro(1'b1, 10); repeat (2) tick();
            if (f == 2) cont = 1'b0;
            drive_frame(18, 66, -1, 0, 2, -1, -1);
            if (f == 0) chk_gap = 1'b1;
        end
        repeat (10) tick();
        chk_gap = 1'b0;
        chk("cont_aro_falls", aro_falls, 3); chk("cont_eof", eof_cnt, 3);
        chk("cont_pxv", pxv_cnt, 3564); chk("cont_sof", sof_cnt, 3); chk("cont_eol", eol_cnt, 54);
        chk("cont_width", width, 66); chk("cont_geom", geom_cnt, 0); chk("cont_busy", busy, 0);

        // Timeout with the sensor silent
        clr();
        trig = 1'b1; tick(); tc = cyc; trig = 1'b0;
        n = 0;
        while (to_cnt == 0 && n < 4300) begin tick(); n++; end
        chk("to_latency", to_cyc - tc, 4100);
        tick();
        chk("to_count", to_cnt, 1); chk("to_busy", busy, 0); chk("to_aro", aro, 1);
        chk("to_eof", eof_cnt, 0);

        // Geometry: one 65-pixel line in a 17-line frame
        clr(); start_frame();
        drive_frame(17, 66, 3, 0, 0, -1, -1);
        repeat (8) tick();
        chk("geo_eol_err", geom_eol_cnt, 1); chk("geo_w", geom_w, 65);
        chk("geo_eof_err", geom_eof_cnt, 1); chk("geo_h", geom_h, 17);
        chk("geo_total", geom_cnt, 2); chk("geo_pxv", pxv_cnt, 1121); chk("geo_eol", eol_cnt, 17);
        chk("geo_height", height, 17); chk("geo_width", width, 66);

        // Reset at pixel 30 of row 5
        clr(); start_frame();
        drive_frame(18, 66, -1, 0, 0, 5, 30);
        chk("mr_aro", aro, 1); chk("mr_pxv", pxv, 0); chk("mr_pxd", pxd, 0);
        chk("mr_width", width, 0); chk("mr_height", height, 0); chk("mr_busy", busy, 0);
        chk("mr_flags", {sof, eol, eof, err_geom, err_timeout}, 0);
        repeat (10) tick();
        chk("mr_no_eof", eof_cnt, 0);
        clr(); start_frame();
        drive_frame(18, 66, -1, 0, 0, -1, -1);
        repeat (8) tick();
        chk("mr2_pxv", pxv_cnt, 1188); chk("mr2_sof", sof_cnt, 1); chk("mr2_eol", eol_cnt, 18);
        chk("mr2_eof", eof_cnt, 1); chk("mr2_width", width, 66); chk("mr2_height", height, 18);
        chk("mr2_geom", geom_cnt, 0);

        // VACT drops while HACT is still high on the 4th line (10 pixels)
        clr(); start_frame();
        drive_frame(4, 66, -1, 10, 0, -1, -1);
        repeat (8) tick();
        chk("tr_pxv", pxv_cnt, 208); chk("tr_eol", eol_cnt, 4); chk("tr_eof", eof_cnt, 1);
        chk("tr_eof_gap", eof_cyc - eol_cyc, 1); chk("tr_height", height, 4); chk("tr_width", width, 10);
        chk("tr_geom_w", geom_w, 10); chk("tr_geom_h", geom_h, 4);
        chk("tr_geom", geom_eol_cnt + geom_eof_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
